// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand magnitudes,
// with early completion for divide-by-zero and signed-overflow divides.
module alu_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          op_q;
  logic                neg_q;    // sign of product / quotient
  logic                rneg_q;   // sign of remainder (dividend's sign)
  logic [2*XLEN-1:0]   prod_q;   // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     mcand_q;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]     res_q;

  function automatic logic [2*XLEN-1:0] fix_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] fix_narrow(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Request decode: signedness, magnitudes and early-completion results
  logic            is_div, a_sgn, b_sgn, sa_d, sb_d, div0_d, ovf_d, fast_d;
  logic [XLEN-1:0] mag_a_d, mag_b_d, fast_res_d;

  always_comb begin
    is_div     = in_op[2];
    a_sgn      = (in_op == 3'b000) || (in_op == 3'b001) || (in_op == 3'b010) ||
                 (in_op == 3'b100) || (in_op == 3'b110);
    b_sgn      = (in_op == 3'b000) || (in_op == 3'b001) || (in_op == 3'b100) ||
                 (in_op == 3'b110);
    sa_d       = a_sgn & in_a[XLEN-1];
    sb_d       = b_sgn & in_b[XLEN-1];
    mag_a_d    = fix_narrow(in_a, sa_d);
    mag_b_d    = fix_narrow(in_b, sb_d);
    div0_d     = is_div && (in_b == '0);
    ovf_d      = is_div && !in_op[0] && (in_a == MIN_NEG) && (in_b == '1);
    fast_d     = div0_d || ovf_d;
    fast_res_d = '1;
    if (div0_d)     fast_res_d = in_op[1] ? in_a : '1;
    else if (ovf_d) fast_res_d = in_op[1] ? '0 : in_a;
  end

  // Iteration step and final sign fix-up
  logic [XLEN:0]     sum_d, rem_sh_d, diff_d;
  logic [2*XLEN-1:0] step_d, full_d;
  logic [XLEN-1:0]   final_d;

  always_comb begin
    sum_d    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    rem_sh_d = prod_q[2*XLEN-1:XLEN-1];
    diff_d   = rem_sh_d - {1'b0, mcand_q};
    step_d   = '0;
    if (!op_q[2]) begin
      if (prod_q[0]) step_d = {sum_d, prod_q[XLEN-1:1]};
      else           step_d = {1'b0, prod_q[2*XLEN-1:1]};
    end else begin
      if (!diff_d[XLEN]) step_d = {diff_d[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
      else               step_d = {rem_sh_d[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end
    full_d  = fix_wide(step_d, neg_q);
    final_d = '0;
    if (!op_q[2])    final_d = (op_q[1:0] == 2'b00) ? full_d[XLEN-1:0] : full_d[2*XLEN-1:XLEN];
    else if (op_q[1]) final_d = fix_narrow(step_d[2*XLEN-1:XLEN], rneg_q);
    else              final_d = fix_narrow(step_d[XLEN-1:0], neg_q);
  end

  assign in_ready   = !rst && !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      res_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (in_valid && in_ready) begin
      op_q   <= in_op;
      neg_q  <= sa_d ^ sb_d;
      rneg_q <= sa_d;
      if (fast_d) begin
        state_q <= DONE;
        cnt_q   <= '0;
        res_q   <= fast_res_d;
      end else begin
        state_q <= CALC;
        cnt_q   <= CNT_W'(XLEN);
        prod_q  <= {{XLEN{1'b0}}, (is_div ? mag_a_d : mag_b_d)};
        mcand_q <= is_div ? mag_b_d : mag_a_d;
      end
    end else begin
      case (state_q)
        CALC: begin
          prod_q <= step_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_q   <= final_d;
            state_q <= DONE;
          end
        end
        DONE:    if (out_ready) state_q <= IDLE;
        default: state_q <= state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (XLEN=32): results, latency, stalls, flush and reset.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // Issues one request; lat counts rising edges with the acceptance edge as edge 1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit consume, output logic [31:0] res, output int lat,
                        output bit busy_ok);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    if (consume) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL rst_out_result: got %h want 0", out_result); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_during: got %b want 0", in_ready); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_mul;
    logic [31:0] r; int lat; bit bok;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_res: got %h want ffffffeb", r); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
    n_cmp++; if (bok !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %b want 1", bok); end
    run_op(3'b001, 32'h80000000, 32'h80000000, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL mulh_res: got %h want 40000000", r); end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_res: got %h want fffffffe", r); end
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_res: got %h want ffffffff", r); end
    run_op(3'b011, 32'd12345, 32'd1000, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mulhu_small: got %h want 0", r); end
  endtask

  task automatic test_div;
    logic [31:0] r; int lat; bit bok;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_res: got %h want fffffffd", r); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_res: got %h want ffffffff", r); end
    run_op(3'b101, 32'd100, 32'd7, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_res: got %0d want 14", r); end
    run_op(3'b111, 32'd100, 32'd7, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_res: got %0d want 2", r); end
    run_op(3'b111, 32'hFFFFFFFF, 32'h80000000, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL remu_big: got %h want 7fffffff", r); end
  endtask

  task automatic test_fast_path;
    logic [31:0] r; int lat; bit bok;
    run_op(3'b101, 32'd5, 32'd0, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_res: got %h want ffffffff", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL divu0_latency: got %0d want 1", lat); end
    run_op(3'b111, 32'd5, 32'd0, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu0_res: got %h want 5", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL remu0_latency: got %0d want 1", lat); end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_res: got %h want 80000000", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_ovf_res: got %h want 0", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rem_ovf_latency: got %0d want 1", lat); end
    run_op(3'b100, 32'hFFFFFFFB, 32'd0, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_signed: got %h want ffffffff", r); end
    run_op(3'b110, 32'hFFFFFFFB, 32'd0, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL rem0_signed: got %h want fffffffb", r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int lat; bit bok;
    run_op(3'b000, 32'd6, 32'd7, 1'b0, r, lat, bok);
    n_cmp++; if (r !== 32'd42) begin n_fail++; $display("FAIL hold_first_res: got %0d want 42", r); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== 32'd42) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got valid=%b res=%0d want valid=1 res=42", i, out_valid, out_result);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'b101; in_a = 32'd1000; in_b = 32'd10;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b valid=%b want busy=1 valid=0", busy, out_valid);
    end
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    n_cmp++; if (out_result !== 32'd100) begin n_fail++; $display("FAIL b2b_res: got %0d want 100", out_result); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_flush_and_rst;
    logic [31:0] r; int lat; bit bok; bit seen;
    // flush during CALC cycle 10, with a competing request held high
    @(negedge clk); in_valid = 1'b1; in_op = 3'b000; in_a = 32'd3; in_b = 32'd5;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got busy=%b valid=%b want 0/0", busy, out_valid);
    end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_result: got valid seen=%b want 0", seen); end
    // reset during CALC cycle 20
    @(negedge clk); in_valid = 1'b1; in_op = 3'b011; in_a = 32'hFFFF0000; in_b = 32'hFFFF0000;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b valid=%b res=%h want 0/0/0", busy, out_valid, out_result);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result: got valid seen=%b want 0", seen); end
    run_op(3'b000, 32'd3, 32'd4, 1'b1, r, lat, bok);
    n_cmp++; if (r !== 32'd12) begin n_fail++; $display("FAIL post_rst_mul: got %0d want 12", r); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL post_rst_latency: got %0d want 33", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_back_to_back();
    test_flush_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
